// File: rtl/sm_cmd_ser.sv
// Command serializer feeding sm_seq: queues whole transactions in a small FIFO
// and replays them one 32-bit word per clock in op/address/data order.
module sm_cmd_ser #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int RD_GAP = 1
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [31:0]                  cmd_data,
  output logic [31:0]                  into,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int GW = $clog2(RD_GAP+1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WT_WD  = 2'b01;
  localparam logic [1:0] OP_WT_BLK = 2'b10;
  localparam logic [1:0] OP_RD_WD  = 2'b11;

  typedef enum logic [2:0] {IDLE, OPW, ADRW, DATW, GAP} state_t;

  state_t state, next_state;

  logic [1:0]        fifo_op   [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [31:0]       fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic [1:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_data;
  logic [1:0]        beat;
  logic [GW-1:0]     gap_cnt;

  logic        push, pop, seq_done, load;
  logic [31:0] into_nxt;
  logic [1:0]  head_op;

  function automatic logic [31:0] op_word(input logic [1:0] op);
    case (op)
      OP_WT_WD:  op_word = {4'b0010, 28'h0};
      OP_WT_BLK: op_word = {4'b0011, 28'h0};
      OP_RD_WD:  op_word = {4'b0100, 28'h0};
      default:   op_word = 32'h0;
    endcase
  endfunction

  // Ready never looks at a same-cycle pop, so a full FIFO always stalls the producer.
  assign cmd_ready = rst_ && (level < LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head_op   = fifo_op[rd_ptr];
  assign busy      = (level != '0) || (state != IDLE);

  assign seq_done = (state == DATW && (cur_op == OP_WT_WD || beat == 2'd3)) ||
                    (state == GAP  && gap_cnt == GW'(RD_GAP));
  assign load     = (state == IDLE || seq_done) && (level != '0);

  always_ff @(posedge clk) begin
    if (!rst_) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      OPW:  next_state = ADRW;
      ADRW: next_state = (cur_op == OP_RD_WD) ? GAP : DATW;
      IDLE, DATW, GAP: begin
        if (state == IDLE || seq_done) begin
          if (load && head_op != OP_NOP) next_state = OPW;
          else                           next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    into_nxt = 32'h0;
    pop      = load;
    case (state)
      OPW:  into_nxt = {{(32-ADDR_W){1'b0}}, cur_addr};
      ADRW: into_nxt = (cur_op == OP_RD_WD) ? 32'h0 : cur_data;
      DATW: if (!seq_done) into_nxt = into + 32'd1;
      default: into_nxt = 32'h0;
    endcase
    if (load) into_nxt = op_word(head_op);
  end

  // FIFO storage is plain data; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= cmd_op;
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      into     <= 32'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cur_op   <= OP_NOP;
      cur_addr <= '0;
      cur_data <= 32'h0;
      beat     <= 2'd0;
      gap_cnt  <= '0;
    end else begin
      into <= into_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (load) begin
        cur_op   <= head_op;
        cur_addr <= fifo_addr[rd_ptr];
        cur_data <= fifo_data[rd_ptr];
      end
      if (state == ADRW) begin
        beat    <= 2'd0;
        gap_cnt <= GW'(1);
      end
      if (state == DATW) beat    <= beat + 2'd1;
      if (state == GAP)  gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule

// File: tb/tb_sm_cmd_ser.sv
// Bench for sm_cmd_ser: a table of commands with hand-derived word streams feeds
// a scoreboard that is checked against into/level/busy/cmd_ready every clock.
module tb_sm_cmd_ser;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int RD_GAP = 1;

  logic              clk = 1'b0;
  logic              rst_;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic [31:0]       into;
  logic              busy;
  logic [2:0]        level;

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                n;
    logic [5:0][31:0]  exp;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    bit          first;
    bit          nop;
  } exp_t;

  vec_t tbl[9];
  vec_t drv_rec;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lvl_m  = 0;
  bit   seq_busy_m = 1'b0;

  sm_cmd_ser #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_GAP(RD_GAP)) dut (
    .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .into(into), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                                 input logic [31:0] d, input int n,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3,
                                 input logic [31:0] w4, input logic [31:0] w5);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.n = n;
    v.exp[0] = w0; v.exp[1] = w1; v.exp[2] = w2;
    v.exp[3] = w3; v.exp[4] = w4; v.exp[5] = w5;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: words of a command accepted at edge N are expected from edge N+1 on.
  task automatic monitorLoop();
    logic rs, pushed;
    vec_t rec;
    exp_t w;
    logic [31:0] exp_into;
    forever begin
      @(posedge clk);
      rs     = rst_;
      pushed = cmd_valid && cmd_ready;
      rec    = drv_rec;
      #1;
      if (!rs) begin
        exp_q.delete();
        lvl_m = 0;
        seq_busy_m = 1'b0;
        checkOutput("rst_into",  into, 32'h0);
        checkOutput("rst_level", 32'(level), 32'h0);
        checkOutput("rst_busy",  32'(busy), 32'h0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'h0);
      end else begin
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          exp_into = w.word;
          if (w.first) lvl_m--;
          seq_busy_m = !w.nop;
        end else begin
          exp_into = 32'h0;
          seq_busy_m = 1'b0;
        end
        if (pushed) begin
          lvl_m++;
          for (int i = 0; i < rec.n; i++)
            exp_q.push_back('{word: rec.exp[i], first: (i == 0), nop: (rec.op == 2'b00)});
        end
        checkOutput("into",  into, exp_into);
        checkOutput("level", 32'(level), 32'(lvl_m));
        checkOutput("busy",  32'(busy), 32'((lvl_m != 0) || seq_busy_m));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(lvl_m < DEPTH));
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    drv_rec   = v;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_stall: cmd_ready stuck low, got 0 expected 1");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic dropValid();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d words pending, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int guard;
    tbl[0] = mkVec(2'b01, 10'h100, 32'haa, 3, 32'h2000_0000, 32'h100, 32'haa, 0, 0, 0);
    tbl[1] = mkVec(2'b10, 10'h040, 32'ha10, 6, 32'h3000_0000, 32'h40,
                   32'ha10, 32'ha11, 32'ha12, 32'ha13);
    tbl[2] = mkVec(2'b11, 10'h040, 32'h0, 3, 32'h4000_0000, 32'h40, 32'h0, 0, 0, 0);
    tbl[3] = mkVec(2'b11, 10'h041, 32'h0, 3, 32'h4000_0000, 32'h41, 32'h0, 0, 0, 0);
    tbl[4] = mkVec(2'b11, 10'h042, 32'h0, 3, 32'h4000_0000, 32'h42, 32'h0, 0, 0, 0);
    tbl[5] = mkVec(2'b11, 10'h043, 32'h0, 3, 32'h4000_0000, 32'h43, 32'h0, 0, 0, 0);
    tbl[6] = mkVec(2'b10, 10'h3ff, 32'hFFFF_FFFE, 6, 32'h3000_0000, 32'h3ff,
                   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1);
    tbl[7] = mkVec(2'b00, 10'h123, 32'h5, 1, 32'h0, 0, 0, 0, 0, 0);
    tbl[8] = mkVec(2'b01, 10'h2a5, 32'hdead_beef, 3, 32'h2000_0000, 32'h2a5,
                   32'hdead_beef, 0, 0, 0);

    rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = 32'h0;
    drv_rec = tbl[0];
    fork
      monitorLoop();
    join_none

    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] table commands back-to-back");
    for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);
    dropValid();
    waitIdle("table");

    $display("[TB] DEPTH+2 writes with valid held");
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(mkVec(2'b01, 10'(i + 8'h10), 32'(32'h1000 + i), 3, 32'h2000_0000,
                          32'(i + 8'h10), 32'(32'h1000 + i), 0, 0, 0));
    dropValid();
    waitIdle("full");

    $display("[TB] reset during third block beat");
    applyStimulus(mkVec(2'b10, 10'h011, 32'h5550, 6, 32'h3000_0000, 32'h11,
                        32'h5550, 32'h5551, 32'h5552, 32'h5553));
    applyStimulus(mkVec(2'b01, 10'h0e0, 32'h77, 3, 32'h2000_0000, 32'he0, 32'h77, 0, 0, 0));
    applyStimulus(mkVec(2'b01, 10'h0e1, 32'h88, 3, 32'h2000_0000, 32'he1, 32'h88, 0, 0, 0));
    dropValid();
    guard = 0;
    while (into !== 32'h5552 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("[TB] FAIL beat3_seen: into %h expected 00005552", into);
    end
    rst_ = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(mkVec(2'b01, 10'h155, 32'hcafe, 3, 32'h2000_0000, 32'h155, 32'hcafe, 0, 0, 0));
    dropValid();
    waitIdle("post_reset");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_cmd_ser.md
Name: sm_cmd_ser

Overview:
Command serializer directly upstream of sm_seq. It accepts whole memory transactions (op, address, data) on a valid/ready interface and buffers them in a small FIFO. It then emits them one word per clock on the 32-bit `into` stream in the exact op-word/address/data order sm_seq consumes. The block replaces hand-timed task stimulus with a synthesizable front end.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
ADDR_W, 10, address width (matches sm_seq/beh_sram addr)
RD_GAP, 1, nop words emitted after a RD_WD address word (≥1)

Ports:
clk  in  1  clock, all logic on posedge
rst_  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept
cmd_op  in  2  00 NOP, 01 WT_WD, 10 WT_BLK, 11 RD_WD
cmd_addr  in  ADDR_W  target address
cmd_data  in  32  write data (WT_BLK: base value)
into  out  32  registered word stream to sm_seq
busy  out  1  FIFO non-empty or sequence in progress
level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst_ low at posedge): into=0, level=0, busy=0, cmd_ready=0 while rst_ low, FSM=IDLE, FIFO flushed. cmd_ready=1 in the first cycle after release.
- Reset mid-sequence aborts the sequence. into=0 from that edge, and queued commands are discarded.
- Accept: cmd_valid&&cmd_ready at posedge pushes {op,addr,data}. cmd_ready = (level<DEPTH) and is independent of same-cycle pop (no full pass-through).
- Op-word encoding: NOP 32'h0; WT_WD {4'b0010,28'h0}; WT_BLK {4'b0011,28'h0}; RD_WD {4'b0100,28'h0}.
- Address word: {(32-ADDR_W)'b0, addr}.
- FSM states: IDLE, OPW, ADRW, DATW, GAP.
  - IDLE: if FIFO non-empty at posedge, pop and load into=op word, then go to OPW (NOP op: into=0, stay IDLE). Otherwise into=0.
  - OPW -> ADRW: into=addr word.
  - ADRW -> DATW for WT_WD/WT_BLK: into=data, beat counter=0.
  - ADRW -> GAP for RD_WD: into=0, gap counter=1.
  - DATW: WT_WD ends after 1 beat. WT_BLK emits data, data+1, data+2, data+3 (mod 2^32; 32'hFFFFFFFF wraps to 0), 4 beats.
  - GAP: holds into=0 for RD_GAP cycles total.
  - End of sequence: if FIFO non-empty, pop and load next op word on the same edge (zero idle gap), go to OPW. Else into=0 and go to IDLE.
- Word counts per command: NOP 1, WT_WD 3, WT_BLK 6, RD_WD 2+RD_GAP.
- Latency: a command pushed at edge N into an empty, idle block has its op word on into from edge N+1. Each word is held exactly one clock.
- level increments on push, decrements on pop, and is unchanged on simultaneous push+pop.
- busy = (level!=0) || (state!=IDLE).
- Command fields are captured at push. Later changes on cmd_* do not affect queued entries.

Test Plan:
- Reset then idle 5 clocks -> into=0, busy=0, level=0, cmd_ready=1 after first post-reset edge.
- Push WT_WD addr 'h100 data 'haa at edge N -> into = 32'h2000_0000, 32'h100, 32'haa on edges N+1..N+3, then 0. sram[0x100] reads back 'haa via sm_seq.
- Push WT_BLK addr 'h40 data 'ha10, then RD_WD 'h40..'h43 back-to-back -> 6 block words with data a10..a13, then each read op/addr followed by RD_GAP zeros, no idle gaps. out_wire returns a10..a13.
- WT_BLK data 32'hFFFF_FFFE -> data words FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Hold cmd_valid with DEPTH+2 WT_WD commands -> cmd_ready drops when level=DEPTH, no entry lost or duplicated, and all words appear in order.
- Assert rst_ low during the 3rd WT_BLK data beat -> into=0 from that edge, level=0, queued commands never emitted, and normal operation after release.
